// File: rtl/menu_fsm_multi_if.sv
// rtl/menu_fsm_multi_if.sv - Front-end inputs and screen/arrow/control outputs of the menu flow controller
//
// Purpose: bundles the button/keyboard inputs and the render-side outputs of
// menu_fsm_multi so the racer top level can pass them as one port.
// Ports (members):
//   btnU/btnD/btnL/btnR  board buttons, level
//   key[5:0]             one-hot keys {esc,enter,right,left,down,up}, level
//   keycode[7:0]         raw scancode, nonzero while any key is held
//   *_visible            screen visibility flags
//   arrow_visible, arrow_xpos, arrow_ypos   selector arrow
//   car_sel, ctrl_sel    latched choices
//   controls[3:0]        {right,left,down,up} player input
// Modports: master drives the inputs (front end / bench), slave is the controller.

interface menu_fsm_multi_if;
  logic        btnU;
  logic        btnD;
  logic        btnL;
  logic        btnR;
  logic [5:0]  key;
  logic [7:0]  keycode;
  logic        title_visible;
  logic        car_select_visible;
  logic        control_select_visible;
  logic        game_visible;
  logic        pause_visible;
  logic        arrow_visible;
  logic [10:0] arrow_xpos;
  logic [10:0] arrow_ypos;
  logic [2:0]  car_sel;
  logic [1:0]  ctrl_sel;
  logic [3:0]  controls;

  modport master (
    output btnU, btnD, btnL, btnR, key, keycode,
    input  title_visible, car_select_visible, control_select_visible,
    input  game_visible, pause_visible, arrow_visible, arrow_xpos, arrow_ypos,
    input  car_sel, ctrl_sel, controls
  );

  modport slave (
    input  btnU, btnD, btnL, btnR, key, keycode,
    output title_visible, car_select_visible, control_select_visible,
    output game_visible, pause_visible, arrow_visible, arrow_xpos, arrow_ypos,
    output car_sel, ctrl_sel, controls
  );
endinterface

// File: rtl/menu_fsm_multi.sv
// rtl/menu_fsm_multi.sv - Game-flow controller: title, car select, control select, game, pause
//
// Purpose: sequences the racer screens from edge-detected navigation events,
// tracks the selector arrow, latches the car/control choice and routes the
// chosen control scheme to the player control vector.
// Ports:
//   pclk  clock
//   rst   synchronous, active-high reset
//   io    menu_fsm_multi_if.slave (buttons/keys in, screen flags/arrow/choices/controls out)

module menu_fsm_multi #(
  parameter int NUM_CARS     = 2,
  parameter int NUM_CTRL     = 2,
  parameter int DELAY        = 10000000,
  parameter int ARROW_X0     = 270,
  parameter int ARROW_XSTEP  = 400,
  parameter int CAR_ARROW_Y  = 480,
  parameter int CTRL_ARROW_Y = 576
) (
  input logic             pclk,
  input logic             rst,
  menu_fsm_multi_if.slave io
);

  localparam int CW = $clog2(DELAY + 1);

  // Bit positions of the navigation event vector.
  localparam int E_CONF  = 0;
  localparam int E_LEFT  = 1;
  localparam int E_RIGHT = 2;
  localparam int E_BACK  = 3;
  localparam int E_ANY   = 4;
  localparam int E_ESC   = 5;

  typedef enum logic [2:0] {
    S_TITLE, S_CAR, S_CTRL, S_GAME, S_PAUSE, S_WAIT
  } state_t;

  state_t state, state_nx;
  state_t target, target_nx;   // screen entered when WAIT expires
  state_t src, src_nx;         // screen shown while in WAIT

  logic [5:0]    raw;
  logic [5:0]    samp_q;
  logic [5:0]    hist_q;
  logic [5:0]    ev;
  logic [CW-1:0] cnt;
  logic          wait_done;
  logic [2:0]    car_idx;
  logic [1:0]    ctrl_idx;
  logic [2:0]    car_sel_q;
  logic [1:0]    ctrl_sel_q;
  logic [3:0]    ctl_next;
  logic [3:0]    ctl_q;
  logic          mv_right;
  logic          mv_left;
  logic [10:0]   arrow_x;
  logic [10:0]   arrow_y;
  logic [10:0]   x_hold_q;
  logic [10:0]   y_hold_q;
  logic [2:0]    idx_sel;

  // Level view of the navigation inputs.
  always_comb begin
    raw         = '0;
    raw[E_CONF]  = io.btnU | io.key[4];
    raw[E_LEFT]  = io.btnL | io.key[2];
    raw[E_RIGHT] = io.btnR | io.key[3];
    raw[E_BACK]  = io.btnD | io.key[5];
    raw[E_ANY]   = io.btnU | io.btnD | io.btnL | io.btnR | (|io.key) | (|io.keycode);
    raw[E_ESC]   = io.key[5];
  end

  // Rising edge between the last two samples; both stages reset to ones so a
  // key held through reset never looks like a fresh press.
  assign ev        = samp_q & ~hist_q;
  assign wait_done = (state == S_WAIT) && (cnt == CW'(DELAY - 1));
  assign mv_right  = ev[E_RIGHT] & ~ev[E_LEFT];
  assign mv_left   = ev[E_LEFT] & ~ev[E_RIGHT];

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state  <= S_TITLE;
      target <= S_TITLE;
      src    <= S_TITLE;
    end else begin
      state  <= state_nx;
      target <= target_nx;
      src    <= src_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    src_nx    = src;
    case (state)
      S_TITLE: if (ev[E_ANY]) begin
        state_nx = S_WAIT; target_nx = S_CAR; src_nx = S_TITLE;
      end
      S_CAR: if (ev[E_CONF]) begin
        state_nx = S_WAIT; target_nx = S_CTRL; src_nx = S_CAR;
      end
      S_CTRL: begin
        if (ev[E_CONF]) begin
          state_nx = S_WAIT; target_nx = S_GAME; src_nx = S_CTRL;
        end else if (ev[E_BACK]) begin
          state_nx = S_WAIT; target_nx = S_CAR; src_nx = S_CTRL;
        end
      end
      S_GAME: if (ev[E_ESC]) state_nx = S_PAUSE;
      S_PAUSE: begin
        if (ev[E_CONF]) begin
          state_nx = S_GAME;
        end else if (ev[E_ESC]) begin
          state_nx = S_WAIT; target_nx = S_TITLE; src_nx = S_PAUSE;
        end
      end
      S_WAIT: if (wait_done) state_nx = target;
      default: state_nx = S_TITLE;
    endcase
  end

  // Control-scheme routing; the value is registered and only shown in GAME.
  always_comb begin
    case (ctrl_sel_q)
      2'd0:    ctl_next = io.key[3:0];
      2'd1:    ctl_next = {io.btnR, io.btnL, io.btnD, io.btnU};
      default: ctl_next = io.key[3:0] | {io.btnR, io.btnL, io.btnD, io.btnU};
    endcase
  end

  // Datapath: edge history, WAIT counter, selection indices and latches.
  always_ff @(posedge pclk) begin
    if (rst) begin
      samp_q     <= '1;
      hist_q     <= '1;
      cnt        <= '0;
      car_idx    <= '0;
      ctrl_idx   <= '0;
      car_sel_q  <= '0;
      ctrl_sel_q <= '0;
      ctl_q      <= '0;
      x_hold_q   <= '0;
      y_hold_q   <= '0;
    end else begin
      samp_q   <= raw;
      hist_q   <= samp_q;
      cnt      <= (state == S_WAIT && !wait_done) ? cnt + CW'(1) : '0;
      ctl_q    <= ctl_next;
      x_hold_q <= arrow_x;
      y_hold_q <= arrow_y;
      case (state)
        S_CAR: begin
          if (ev[E_CONF])
            car_sel_q <= car_idx;
          else if (mv_right)
            car_idx <= (car_idx == 3'(NUM_CARS - 1)) ? 3'd0 : car_idx + 3'd1;
          else if (mv_left)
            car_idx <= (car_idx == 3'd0) ? 3'(NUM_CARS - 1) : car_idx - 3'd1;
        end
        S_CTRL: begin
          if (ev[E_CONF])
            ctrl_sel_q <= ctrl_idx;
          else if (!ev[E_BACK]) begin
            if (mv_right)
              ctrl_idx <= (ctrl_idx == 2'(NUM_CTRL - 1)) ? 2'd0 : ctrl_idx + 2'd1;
            else if (mv_left)
              ctrl_idx <= (ctrl_idx == 2'd0) ? 2'(NUM_CTRL - 1) : ctrl_idx - 2'd1;
          end
        end
        S_WAIT: begin
          // Choices restart from the first entry whenever the title comes back.
          if (wait_done && target == S_TITLE) begin
            car_idx  <= '0;
            ctrl_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    state_t scr;
    scr = (state == S_WAIT) ? src : state;
    io.title_visible          = (scr == S_TITLE);
    io.car_select_visible     = (scr == S_CAR);
    io.control_select_visible = (scr == S_CTRL);
    io.game_visible           = (scr == S_GAME) || (scr == S_PAUSE);
    io.pause_visible          = (scr == S_PAUSE);
    io.arrow_visible          = (state == S_CAR) || (state == S_CTRL);
    io.controls               = (state == S_GAME) ? ctl_q : 4'd0;

    idx_sel = (state == S_CTRL) ? {1'b0, ctrl_idx} : car_idx;
    arrow_x = x_hold_q;
    arrow_y = y_hold_q;
    if (state == S_CAR || state == S_CTRL) begin
      arrow_x = 11'(ARROW_X0 + ARROW_XSTEP * int'(idx_sel));
      arrow_y = (state == S_CAR) ? 11'(CAR_ARROW_Y) : 11'(CTRL_ARROW_Y);
    end
  end

  assign io.arrow_xpos = arrow_x;
  assign io.arrow_ypos = arrow_y;
  assign io.car_sel    = car_sel_q;
  assign io.ctrl_sel   = ctrl_sel_q;

endmodule

// File: tb/tb_menu_fsm_multi.sv
// tb/tb_menu_fsm_multi.sv - Self-checking bench for menu_fsm_multi

module tb_menu_fsm_multi;
  localparam int NUM_CARS = 3;
  localparam int NUM_CTRL = 3;
  localparam int DELAY    = 4;
  localparam int X0       = 270;
  localparam int XSTEP    = 400;
  localparam int CAR_Y    = 480;
  localparam int CTRL_Y   = 576;

  localparam int TITLE = 0, CAR = 1, CTRL = 2, GAME = 3, PAUSE = 4, WAITING = 5;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  menu_fsm_multi_if io ();

  menu_fsm_multi #(
    .NUM_CARS(NUM_CARS), .NUM_CTRL(NUM_CTRL), .DELAY(DELAY),
    .ARROW_X0(X0), .ARROW_XSTEP(XSTEP), .CAR_ARROW_Y(CAR_Y), .CTRL_ARROW_Y(CTRL_Y)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .io(io.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: current screen, remaining WAIT cycles, selections.
  int         m_scr, m_tgt, m_src, m_wait_left;
  int         m_car, m_ctrl, m_car_sel, m_ctrl_sel;
  int         m_last_x, m_last_y;
  logic [3:0] m_ctl;
  logic [5:0] m_s1, m_s2;   // input levels seen at the previous two edges

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // {esc, any, back, right, left, conf}
  function automatic logic [5:0] levels();
    logic [5:0] l;
    l[0] = io.btnU | io.key[4];
    l[1] = io.btnL | io.key[2];
    l[2] = io.btnR | io.key[3];
    l[3] = io.btnD | io.key[5];
    l[4] = io.btnU | io.btnD | io.btnL | io.btnR | (io.key != 0) | (io.keycode != 0);
    l[5] = io.key[5];
    return l;
  endfunction

  task automatic go_wait(input int t);
    m_src       = m_scr;
    m_tgt       = t;
    m_scr       = WAITING;
    m_wait_left = DELAY;
  endtask

  task automatic model_edge();
    logic [5:0] e;
    logic [5:0] lv;
    logic [3:0] kb, bb;
    lv = levels();
    kb = io.key[3:0];
    bb = {io.btnR, io.btnL, io.btnD, io.btnU};
    if (rst) begin
      m_s1 = '1; m_s2 = '1;
      m_scr = TITLE; m_tgt = TITLE; m_src = TITLE; m_wait_left = 0;
      m_car = 0; m_ctrl = 0; m_car_sel = 0; m_ctrl_sel = 0;
      m_ctl = 0; m_last_x = -1; m_last_y = -1;
      return;
    end
    e = m_s1 & ~m_s2;
    m_ctl = (m_ctrl_sel == 0) ? kb : (m_ctrl_sel == 1) ? bb : (kb | bb);
    case (m_scr)
      TITLE: if (e[4]) go_wait(CAR);
      CAR: begin
        if (e[0]) begin m_car_sel = m_car; go_wait(CTRL); end
        else if (e[2] && !e[1]) m_car = (m_car + 1) % NUM_CARS;
        else if (e[1] && !e[2]) m_car = (m_car + NUM_CARS - 1) % NUM_CARS;
      end
      CTRL: begin
        if (e[0]) begin m_ctrl_sel = m_ctrl; go_wait(GAME); end
        else if (e[3]) go_wait(CAR);
        else if (e[2] && !e[1]) m_ctrl = (m_ctrl + 1) % NUM_CTRL;
        else if (e[1] && !e[2]) m_ctrl = (m_ctrl + NUM_CTRL - 1) % NUM_CTRL;
      end
      GAME: if (e[5]) m_scr = PAUSE;
      PAUSE: begin
        if (e[0]) m_scr = GAME;
        else if (e[5]) go_wait(TITLE);
      end
      default: begin
        m_wait_left--;
        if (m_wait_left == 0) begin
          m_scr = m_tgt;
          if (m_tgt == TITLE) begin m_car = 0; m_ctrl = 0; end
        end
      end
    endcase
    m_s2 = m_s1;
    m_s1 = lv;
  endtask

  task automatic check_all();
    int         vs;
    logic [5:0] exp_f, got_f;
    vs    = (m_scr == WAITING) ? m_src : m_scr;
    exp_f = {vs == TITLE, vs == CAR, vs == CTRL, (vs == GAME) || (vs == PAUSE),
             vs == PAUSE, (m_scr == CAR) || (m_scr == CTRL)};
    got_f = {io.title_visible, io.car_select_visible, io.control_select_visible,
             io.game_visible, io.pause_visible, io.arrow_visible};
    chk("flags", 32'(got_f), 32'(exp_f));
    chk("car_sel", 32'(io.car_sel), m_car_sel);
    chk("ctrl_sel", 32'(io.ctrl_sel), m_ctrl_sel);
    chk("controls", 32'(io.controls), (m_scr == GAME) ? 32'(m_ctl) : 32'd0);
    if (m_scr == CAR) begin
      m_last_x = (X0 + m_car * XSTEP) % 2048; m_last_y = CAR_Y;
    end else if (m_scr == CTRL) begin
      m_last_x = (X0 + m_ctrl * XSTEP) % 2048; m_last_y = CTRL_Y;
    end
    if (m_last_x >= 0) begin
      chk("arrow_x", 32'(io.arrow_xpos), m_last_x);
      chk("arrow_y", 32'(io.arrow_ypos), m_last_y);
    end
  endtask

  task automatic cycle();
    @(posedge pclk);
    model_edge();
    @(negedge pclk);
    check_all();
  endtask

  // b = {btnR, btnL, btnD, btnU}
  task automatic drive(input logic [3:0] b, input logic [5:0] k, input logic [7:0] kc);
    {io.btnR, io.btnL, io.btnD, io.btnU} = b;
    io.key     = k;
    io.keycode = kc;
  endtask

  task automatic pulse(input logic [3:0] b, input logic [5:0] k, input logic [7:0] kc);
    drive(b, k, kc);
    cycle();
    drive(4'd0, 6'd0, 8'd0);
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    drive(4'd0, 6'd0, 8'd0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("reset_title", 32'(io.title_visible), 1);
    chk("reset_controls", 32'(io.controls), 0);

    // Title -> WAIT -> car select
    pulse(4'b0100, 6'd0, 8'd0);
    chk("title_wait_flag", 32'(io.title_visible), 1);
    idle(5);
    chk("car_entry_x", 32'(io.arrow_xpos), 270);
    chk("car_entry_y", 32'(io.arrow_ypos), 480);

    // Navigation with wrap
    pulse(4'b1000, 6'd0, 8'd0);
    pulse(4'b1000, 6'd0, 8'd0);
    pulse(4'b1000, 6'd0, 8'd0);
    chk("wrap_right_x", 32'(io.arrow_xpos), 270);
    pulse(4'b0100, 6'd0, 8'd0);
    chk("wrap_left_x", 32'(io.arrow_xpos), 1070);
    drive(4'b1000, 6'd0, 8'd0);
    idle(10);
    drive(4'd0, 6'd0, 8'd0);
    idle(2);
    chk("held_one_step_x", 32'(io.arrow_xpos), 270);
    pulse(4'b0100, 6'd0, 8'd0);

    // Confirm and left in the same cycle: confirm wins, no move
    pulse(4'b0100, 6'b010000, 8'd0);
    chk("car_sel_latch", 32'(io.car_sel), 2);
    chk("wait_arrow_hold", 32'(io.arrow_xpos), 1070);
    chk("wait_arrow_off", 32'(io.arrow_visible), 0);
    idle(5);
    chk("ctrl_screen", 32'(io.control_select_visible), 1);

    // Back to car select, index preserved
    pulse(4'b0010, 6'd0, 8'd0);
    idle(5);
    chk("back_car_x", 32'(io.arrow_xpos), 1070);
    pulse(4'd0, 6'b010000, 8'd0);
    idle(5);
    pulse(4'b1000, 6'd0, 8'd0);
    chk("ctrl_x", 32'(io.arrow_xpos), 670);
    chk("ctrl_y", 32'(io.arrow_ypos), 576);
    pulse(4'd0, 6'b010000, 8'd0);
    chk("ctrl_sel_latch", 32'(io.ctrl_sel), 1);
    idle(5);

    // Game controls with board-button scheme
    drive(4'b1001, 6'd0, 8'd0);
    cycle();
    chk("controls_btn", 32'(io.controls), 9);
    drive(4'd0, 6'b000001, 8'd0);
    cycle();
    chk("controls_key_ignored", 32'(io.controls), 0);
    drive(4'd0, 6'd0, 8'd0);
    cycle();

    // Pause, resume, quit to title
    pulse(4'd0, 6'b100000, 8'd0);
    chk("pause_vis", 32'(io.pause_visible), 1);
    chk("pause_game_vis", 32'(io.game_visible), 1);
    chk("pause_controls", 32'(io.controls), 0);
    pulse(4'd0, 6'b010000, 8'd0);
    chk("resume_pause_off", 32'(io.pause_visible), 0);
    pulse(4'd0, 6'b100000, 8'd0);
    pulse(4'd0, 6'b100000, 8'd0);
    idle(5);
    chk("quit_title", 32'(io.title_visible), 1);
    chk("quit_car_sel", 32'(io.car_sel), 2);

    // Reset during WAIT, button held across reset release
    pulse(4'd0, 6'd0, 8'h1C);
    idle(2);
    rst = 1'b1;
    drive(4'b0001, 6'd0, 8'd0);
    cycle();
    chk("rst_wait_title", 32'(io.title_visible), 1);
    rst = 1'b0;
    idle(10);
    chk("held_through_reset", 32'(io.title_visible), 1);
    drive(4'd0, 6'd0, 8'd0);
    idle(3);
    pulse(4'd0, 6'b010000, 8'd0);
    idle(5);
    chk("idx_cleared_x", 32'(io.arrow_xpos), 270);

    // Randomized sparse stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] b;
      logic [5:0] k;
      logic [7:0] kc;
      for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < 6; j++) k[j] = ($urandom_range(0, 11) == 0);
      kc  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      rst = ($urandom_range(0, 399) == 0);
      drive(b, k, kc);
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/menu_fsm_multi.md
Name: menu_fsm_multi

Overview:
Parametrised game-flow controller for the racer top level. It sequences the title, car select, control select, game and pause screens, and drives screen-visibility flags, the selector arrow position, the latched car/control choice and the 4-bit player control vector. It supports N cars, 2–3 control schemes, edge-detected navigation with wrap-around, a back/pause path, and a programmable screen-change delay. It sits between the keyboard/button front end and the sprite/render blocks.

Parameters:
- NUM_CARS, 2, selectable cars (2..8)
- NUM_CTRL, 2, control schemes (2 or 3): 0 keyboard, 1 board buttons, 2 both ORed
- DELAY, 10000000, cycles spent in WAIT per screen change (>=1)
- ARROW_X0, 270, arrow x for index 0
- ARROW_XSTEP, 400, arrow x increment per index
- CAR_ARROW_Y, 480, arrow y on car select
- CTRL_ARROW_Y, 576, arrow y on control select

Ports:
- pclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- btnU, btnD, btnL, btnR  in  1 each  board buttons, level
- key  in  6  one-hot keys: [0]up [1]down [2]left [3]right [4]enter [5]esc, level
- keycode  in  8  raw scancode; nonzero means a key is held
- title_visible, car_select_visible, control_select_visible, game_visible, pause_visible  out  1 each  screen flags
- arrow_visible  out  1  arrow enable
- arrow_xpos, arrow_ypos  out  11 each  arrow position
- car_sel  out  3  latched car index
- ctrl_sel  out  2  latched control scheme
- controls  out  4  {right,left,down,up} player input

Behaviour:
- States: TITLE, CAR, CTRL, GAME, PAUSE, WAIT. Reset → TITLE.
- Reset values:
  - car_sel=0, ctrl_sel=0, controls=0.
  - Internal car_idx/ctrl_idx = 0, WAIT counter = 0.
  - Edge-detect history registers = all ones, so inputs held through reset produce no event.
- Events are rising edges of registered history, one cycle of latency:
  - conf = btnU | key[4]
  - left = btnL | key[2]
  - right = btnR | key[3]
  - back = btnD | key[5]
  - any = OR of all buttons, key bits and (keycode != 0)
- Visibility flags are combinational decode of the state register:
  - TITLE → title_visible.
  - CAR → car_select_visible and arrow_visible.
  - CTRL → control_select_visible and arrow_visible.
  - GAME → game_visible.
  - PAUSE → game_visible and pause_visible.
  - WAIT → the source screen's flags, with arrow_visible=0.
- Arrow position:
  - arrow_xpos = ARROW_X0 + idx*ARROW_XSTEP, truncated to 11 bits.
  - arrow_ypos = CAR_ARROW_Y in CAR, CTRL_ARROW_Y in CTRL.
  - Both hold their last value elsewhere.
- TITLE:
  - any event → WAIT, target CAR.
  - car_idx and ctrl_idx are cleared on entry to TITLE.
- CAR:
  - right: car_idx+1, wrapping NUM_CARS-1 → 0.
  - left: car_idx-1, wrapping 0 → NUM_CARS-1.
  - left and right together: no move.
  - conf: car_sel ← car_idx, then WAIT → CTRL. conf has priority over any move in the same cycle.
- CTRL:
  - left/right move ctrl_idx with wrap over NUM_CTRL.
  - conf: ctrl_sel ← ctrl_idx, then WAIT → GAME.
  - back (without conf): WAIT → CAR, car_idx preserved. conf wins over back.
- GAME:
  - controls are registered one cycle after the inputs:
    - ctrl_sel 0 → key[3:0]
    - ctrl_sel 1 → {btnR,btnL,btnD,btnU}
    - ctrl_sel 2 → bitwise OR of both
  - key[5] edge → PAUSE.
- PAUSE:
  - controls=0.
  - conf → GAME immediately, no WAIT.
  - key[5] edge → WAIT → TITLE.
- WAIT:
  - Counter increments from 0; at DELAY-1 the counter clears and state ← target. WAIT therefore lasts exactly DELAY cycles.
  - All events are ignored; controls=0.
  - Counter width is clog2(DELAY+1).
- controls is 0 in every state except GAME.
- rst mid-WAIT or mid-GAME: next cycle is TITLE with all reset values; the pending target is discarded.

Test Plan:
- DELAY=4, NUM_CARS=3. Reset, pulse btnL 1 cycle → TITLE, then 4 cycles of WAIT, then CAR; arrow_xpos=270, arrow_ypos=480.
- In CAR: right ×3 → idx 1,2,0; left once → idx 2, arrow_xpos=1070 (270+800). Hold btnR for 10 cycles → exactly one step.
- In CAR at idx 2: key[4] and btnL in the same cycle → car_sel=2 with no move; WAIT → CTRL.
- In CTRL: btnD → WAIT → CAR with car_idx unchanged. Return to CTRL, right, conf → ctrl_sel=1; in GAME btnU=1, btnR=1 → controls=4'b1001 one cycle later; key[0] alone → controls=0.
- In GAME: key[5] → PAUSE, controls=0, pause_visible=game_visible=1. Enter → GAME the next cycle. key[5] twice → PAUSE, then WAIT, then TITLE with car_sel retained and idx cleared.
- Assert rst during WAIT at counter=2 → TITLE next cycle, counter 0. Hold btnU across reset release → no transition.
